// File: rtl/exp_taylor_seq.sv
// Sequential fixed-point e^x: Horner-form Taylor series, one term per clock,
// reciprocal constants instead of dividers, saturating output behind a valid/ready stream.
module exp_taylor_seq #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int TERMS      = 8,
  parameter int RECIP_FRAC = 16,
  parameter int GUARD      = 4,
  localparam int W         = INT_WIDTH + FRAC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [W-1:0] result,
  output logic                overflow
);

  localparam int ACC_W = W + GUARD;
  localparam int P1_W  = ACC_W + W;
  localparam int RC_W  = RECIP_FRAC + 2;
  localparam int P2_W  = P1_W + RC_W;
  localparam int K_W   = $clog2(TERMS);

  localparam logic signed [P2_W-1:0] ONE_P =
    {{(P2_W-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic signed [P2_W-1:0] ACC_MAX_P = {{(P2_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [P2_W-1:0] ACC_MIN_P = {{(P2_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] RES_MAX_A = {{(GUARD+1){1'b0}}, {(W-1){1'b1}}};

  if (TERMS < 2 || TERMS > 16) begin : g_bad_terms
    $error("exp_taylor_seq: TERMS must lie in 2..16");
  end

  // Rounded-to-nearest 2^RECIP_FRAC / k; 1/1 needs one bit beyond RECIP_FRAC.
  function automatic logic [RECIP_FRAC:0] recip_val(input int k);
    longint num;
    num = (longint'(1) << (RECIP_FRAC + 1)) + longint'(k);
    return (RECIP_FRAC+1)'(num / longint'(2 * k));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                    r_state, w_state_next;
  logic signed [W-1:0]       r_x;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [K_W-1:0]     r_k;
  logic                      r_ovf;
  logic        [W-1:0]       r_result;
  logic                      r_overflow;

  logic        [RECIP_FRAC:0] w_recip_tbl [TERMS];
  logic signed [RC_W-1:0]     w_recip_s;
  logic signed [P1_W-1:0]     w_prod1;
  logic signed [P1_W-1:0]     w_term;
  logic signed [P2_W-1:0]     w_prod2;
  logic signed [P2_W-1:0]     w_sum;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic                       w_clamp;
  logic                       w_ovf_next;
  logic        [W-1:0]        w_res_next;
  logic                       w_res_ovf;

  assign w_recip_tbl[0] = '0;
  for (genvar g = 1; g < TERMS; g++) begin : g_recip
    assign w_recip_tbl[g] = recip_val(g);
  end

  assign w_recip_s = signed'({1'b0, w_recip_tbl[r_k]});
  assign w_prod1   = P1_W'(r_acc) * P1_W'(r_x);
  assign w_term    = w_prod1 >>> FRAC_WIDTH;
  assign w_prod2   = P2_W'(w_term) * P2_W'(w_recip_s);
  assign w_sum     = (w_prod2 >>> RECIP_FRAC) + ONE_P;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_clamp    = 1'b0;
    w_acc_next = $signed(w_sum[ACC_W-1:0]);
    if (w_sum > ACC_MAX_P) begin
      w_acc_next = $signed(ACC_MAX_P[ACC_W-1:0]);
      w_clamp    = 1'b1;
    end else if (w_sum < ACC_MIN_P) begin
      w_acc_next = $signed(ACC_MIN_P[ACC_W-1:0]);
      w_clamp    = 1'b1;
    end
  end

  assign w_ovf_next = r_ovf | w_clamp;

  // Negative results clamp to zero but keep any earlier accumulator saturation visible.
  always_comb begin
    w_res_next = w_acc_next[W-1:0];
    w_res_ovf  = w_ovf_next;
    if (w_acc_next > RES_MAX_A) begin
      w_res_next = {1'b0, {(W-1){1'b1}}};
      w_res_ovf  = 1'b1;
    end else if (w_acc_next[ACC_W-1]) begin
      w_res_next = '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_ITER;
      end
      S_ITER: begin
        if (r_k == K_W'(1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x   <= x;
          r_acc <= ACC_W'(ONE_P);
          r_k   <= K_W'(TERMS - 1);
          r_ovf <= 1'b0;
        end
        S_ITER: begin
          r_acc <= w_acc_next;
          r_k   <= r_k - K_W'(1);
          r_ovf <= w_ovf_next;
          if (r_k == K_W'(1)) begin
            r_result   <= w_res_next;
            r_overflow <= w_res_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_exp_taylor_seq.sv
// Directed bench for exp_taylor_seq: Q8.8 with TERMS=8, plus a TERMS=2 instance.
module tb_exp_taylor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, overflow;
  logic [15:0] x = '0, result;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, overflow2;
  logic [15:0] x2 = '0, result2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exp_taylor_seq #(.TERMS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  exp_taylor_seq #(.TERMS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [15:0] xv, input logic [15:0] exp_res,
                       input logic exp_ovf, input string tag);
    int lat;
    @(negedge clk); x = xv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
    wait_out(lat);
    check({tag, ".lat"}, lat, 32'd8);
    check({tag, ".res"}, 32'(result), 32'(exp_res));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int lat, bad, cyc, ia, ir;
    logic [15:0] vec [3];
    logic [15:0] exp_b [3];
    logic [15:0] got [3];
    int tout [3];

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reset.ready", 32'(in_ready), 32'd1);
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.res",   32'(result), 32'd0);
    check("reset.ovf",   32'(overflow), 32'd0);
    check("reset2.ready", 32'(in_ready2), 32'd1);

    do_op(16'h0000, 16'h0100, 1'b0, "x0");
    do_op(16'h0100, 16'h02B7, 1'b0, "x1");
    do_op(16'hFF00, 16'h005E, 1'b0, "xm1");
    do_op(16'h0080, 16'h01A6, 1'b0, "xhalf");
    do_op(16'h7F00, 16'h7FFF, 1'b1, "x127");
    do_op(16'h0000, 16'h0100, 1'b0, "x0_after_ovf");
    do_op(16'h8000, 16'h0000, 1'b1, "xm128");

    // Stall in DONE with a new operand already offered.
    @(negedge clk); x = 16'h0100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; x = 16'h0080;
    wait_out(lat);
    check("stall.lat", lat, 32'd8);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 16'h02B7 && overflow === 1'b0 && in_ready === 1'b0))
        bad++;
    end
    check("stall.stable", bad, 32'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("stall.idle", 32'({in_ready, out_valid}), 32'b10);
    @(posedge clk); #1; in_valid = 1'b0;
    check("stall.accept2", 32'(in_ready), 32'd0);
    wait_out(lat);
    check("stall.lat2", lat, 32'd8);
    check("stall.res2", 32'(result), 32'h01A6);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset in the middle of an iteration.
    @(negedge clk); x = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.res",   32'(result), 32'd0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("rst.novalid", bad, 32'd0);

    // Back-to-back stream with the sink always ready.
    vec   = '{16'h0000, 16'h0100, 16'hFF00};
    exp_b = '{16'h0100, 16'h02B7, 16'h005E};
    got   = '{16'h0, 16'h0, 16'h0};
    tout  = '{0, 0, 0};
    cyc = 0; ia = 0; ir = 0;
    out_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1 && ir < 3) begin
        got[ir] = result; tout[ir] = cyc; ir++;
      end
      if (ia < 3) begin
        x = vec[ia]; in_valid = 1'b1;
        if (in_ready === 1'b1) ia++;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.count", ir, 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b.res%0d", i), 32'(got[i]), 32'(exp_b[i]));
    check("b2b.gap01", tout[1] - tout[0], 32'd9);
    check("b2b.gap12", tout[2] - tout[1], 32'd9);

    // TERMS=2 instance: 1 + x only.
    begin
      logic [15:0] xs2 [3];
      logic [15:0] rs2 [3];
      logic        os2 [3];
      xs2 = '{16'h0100, 16'h7F00, 16'hFF00};
      rs2 = '{16'h0200, 16'h7FFF, 16'h0000};
      os2 = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); x2 = xs2[i]; in_valid2 = 1'b1; out_ready2 = 1'b0;
        @(posedge clk); #1; in_valid2 = 1'b0;
        lat = 1;
        while (out_valid2 !== 1'b1 && lat < 64) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("t2.lat%0d", i), lat, 32'd2);
        check($sformatf("t2.res%0d", i), 32'(result2), 32'(rs2[i]));
        check($sformatf("t2.ovf%0d", i), 32'(overflow2), 32'(os2[i]));
        @(negedge clk); out_ready2 = 1'b1;
        @(posedge clk); #1; out_ready2 = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
